// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
//
// Writeback controller for the register file write port. It merges
// unthrottled ALU results with handshaked load results, which are buffered in a
// small FIFO. It tracks loads still in flight in a pending scoreboard and
// provides decode-side operands and the decode stall.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   : decode operands are forwarded from the registered write stage.
//   undefined : no forwarding. Decode instead stalls on a write-stage hazard.
//
// Parameters
//   LD_FIFO_DEPTH   load-result FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_alu_valid/rd/data          ALU result (always accepted)
//   i_ld_issue, i_ld_issue_rd    load dispatch, marks rd pending
//   i_ld_valid, o_ld_ready       load result handshake
//   i_ld_rd, i_ld_data           load result payload
//   o_rf_wr/rd/wdata             registered register file write port
//   i_rs1, i_rs2, i_dec_rd       decode source/destination addresses
//   i_rf_rdata1/2                register file asynchronous read data
//   o_rs1_data, o_rs2_data       decode operands
//   o_stall                      decode hold request
// -----------------------------------------------------------------------------
module reg_wb_ctrl #(
    parameter int LD_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_issue_rd,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    output logic        o_rf_wr,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_wdata,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_dec_rd,
    input  logic [31:0] i_rf_rdata1,
    input  logic [31:0] i_rf_rdata2,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic        o_stall
);

    localparam int AW = $clog2(LD_FIFO_DEPTH);

    // Load FIFO storage and pointers (one extra wrap bit)
    logic [4:0]  r_fifo_rd   [LD_FIFO_DEPTH];
    logic [31:0] r_fifo_data [LD_FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    // Pending-load scoreboard for x1..x31
    logic [31:1] r_pending;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic [31:1] w_pending_nxt;
    logic [31:0] w_pend_all;
    logic        w_hazard_ld;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    // Ready depends only on the current fill level. A same-cycle pop does not
    // free a slot for this cycle's push.
    assign o_ld_ready = !w_full;
    assign w_push     = i_ld_valid && !w_full;
    assign w_pop      = !i_alu_valid && !w_empty;

    assign w_head_rd   = r_fifo_rd[r_rptr[AW-1:0]];
    assign w_head_data = r_fifo_data[r_rptr[AW-1:0]];

    // Apply the clear first and the set second, so a set wins on the same rd.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int unsigned i = 1; i < 32; i++) begin
            if (w_pop && (w_head_rd == 5'(i)))
                w_pending_nxt[i] = 1'b0;
            if (i_ld_issue && (i_ld_issue_rd == 5'(i)))
                w_pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr[AW-1:0]]   <= i_ld_rd;
            r_fifo_data[r_wptr[AW-1:0]] <= i_ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pending  <= '0;
            o_rf_wr    <= 1'b0;
            o_rf_rd    <= '0;
            o_rf_wdata <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_pending <= w_pending_nxt;

            // ALU wins the write port. Otherwise drain the FIFO head. A
            // destination of x0 is consumed without enabling the write.
            if (i_alu_valid) begin
                o_rf_wr    <= (i_alu_rd != 5'd0);
                o_rf_rd    <= i_alu_rd;
                o_rf_wdata <= i_alu_data;
            end else if (w_pop) begin
                o_rf_wr    <= (w_head_rd != 5'd0);
                o_rf_rd    <= w_head_rd;
                o_rf_wdata <= w_head_data;
            end else begin
                o_rf_wr    <= 1'b0;
            end
        end
    end

    // Bit 0 is held clear so that x0 never reports a hazard.
    assign w_pend_all  = {r_pending, 1'b0};
    assign w_hazard_ld = w_pend_all[i_rs1] || w_pend_all[i_rs2] ||
                         w_pend_all[i_dec_rd];

`ifdef WB_FORWARD_EN
    always_comb begin
        if (i_rs1 == 5'd0)
            o_rs1_data = '0;
        else if (o_rf_wr && (o_rf_rd == i_rs1))
            o_rs1_data = o_rf_wdata;
        else
            o_rs1_data = i_rf_rdata1;

        if (i_rs2 == 5'd0)
            o_rs2_data = '0;
        else if (o_rf_wr && (o_rf_rd == i_rs2))
            o_rs2_data = o_rf_wdata;
        else
            o_rs2_data = i_rf_rdata2;
    end

    assign o_stall = w_hazard_ld;
`else
    logic w_hazard_wb;

    assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : i_rf_rdata1;
    assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : i_rf_rdata2;

    // Without a bypass, an operand being written this cycle must wait until
    // the register file holds it.
    assign w_hazard_wb = o_rf_wr && (o_rf_rd != 5'd0) &&
                         ((o_rf_rd == i_rs1) || (o_rf_rd == i_rs2));
    assign o_stall = w_hazard_ld || w_hazard_wb;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_issue;
    logic [4:0]  i_ld_issue_rd;
    logic        i_ld_valid;
    logic        o_ld_ready;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic        o_rf_wr;
    logic [4:0]  o_rf_rd;
    logic [31:0] o_rf_wdata;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [4:0]  i_dec_rd;
    logic [31:0] i_rf_rdata1;
    logic [31:0] i_rf_rdata2;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic        o_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_wb_ctrl #(.LD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_issue(i_ld_issue), .i_ld_issue_rd(i_ld_issue_rd),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
        .o_rf_wr(o_rf_wr), .o_rf_rd(o_rf_rd), .o_rf_wdata(o_rf_wdata),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_dec_rd(i_dec_rd),
        .i_rf_rdata1(i_rf_rdata1), .i_rf_rdata2(i_rf_rdata2),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_stall(o_stall)
    );

    // The register file read data is a recognisable function of the address.
    assign i_rf_rdata1 = 32'hA1A1_0000 | 32'(i_rs1);
    assign i_rf_rdata2 = 32'hB2B2_0000 | 32'(i_rs2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    bit          m_init = 0;
    bit          m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            foreach (m_pend[k]) m_pend[k] = 0;
            m_wr = 0; m_rd = 0; m_wdata = 0;
            m_init = 1;
        end else if (m_init) begin
            bit   can_push;
            bit   do_pop;
            ent_t e;
            can_push = i_ld_valid && (m_q.size() < DEPTH);
            do_pop   = !i_alu_valid && (m_q.size() > 0);
            if (i_alu_valid) begin
                m_wr = (i_alu_rd != 0); m_rd = i_alu_rd; m_wdata = i_alu_data;
            end else if (do_pop) begin
                e = m_q.pop_front();
                m_wr = (e.rd != 0); m_rd = e.rd; m_wdata = e.data;
                m_pend[e.rd] = 0;
            end else begin
                m_wr = 0;
            end
            if (can_push) begin
                e.rd = i_ld_rd; e.data = i_ld_data;
                m_q.push_back(e);
            end
            if (i_ld_issue && i_ld_issue_rd != 0) m_pend[i_ld_issue_rd] = 1;
        end
    end

    function automatic logic [31:0] exp_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'h0;
`ifdef WB_FORWARD_EN
        if (m_wr && m_rd == rs) return m_wdata;
`endif
        return rf;
    endfunction

    function automatic logic exp_stall();
        logic s;
        s = (i_rs1 != 0 && m_pend[i_rs1]) || (i_rs2 != 0 && m_pend[i_rs2]) ||
            (i_dec_rd != 0 && m_pend[i_dec_rd]);
`ifndef WB_FORWARD_EN
        if (m_wr && m_rd != 0 && ((i_rs1 != 0 && m_rd == i_rs1) || (i_rs2 != 0 && m_rd == i_rs2)))
            s = 1;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        if (m_init) begin
            chk("rf_wr", 32'(o_rf_wr), 32'(m_wr));
            if (m_wr) begin
                chk("rf_rd", 32'(o_rf_rd), 32'(m_rd));
                chk("rf_wdata", o_rf_wdata, m_wdata);
            end
            chk("ld_ready", 32'(o_ld_ready), 32'(m_q.size() < DEPTH));
            chk("stall", 32'(o_stall), 32'(exp_stall()));
            chk("rs1_data", o_rs1_data, exp_operand(i_rs1, i_rf_rdata1));
            chk("rs2_data", o_rs2_data, exp_operand(i_rs2, i_rf_rdata2));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_ld_issue = 0; i_ld_issue_rd = 0;
        i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0;
        i_rs1 = 0; i_rs2 = 0; i_dec_rd = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        @(negedge clk);
        chk("reset rf_wr", 32'(o_rf_wr), 32'h0);
        chk("reset rf_rd", 32'(o_rf_rd), 32'h0);
        chk("reset rf_wdata", o_rf_wdata, 32'h0);
        chk("reset ld_ready", 32'(o_ld_ready), 32'h1);
        chk("reset stall", 32'(o_stall), 32'h0);
        tick();
        rst = 0;

        // ALU write and forward
        i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'hDEAD_BEEF; i_rs1 = 5;
        tick();
        i_alu_valid = 0;
        @(negedge clk);
        chk("alu rf_wr", 32'(o_rf_wr), 32'h1);
        chk("alu rf_rd", 32'(o_rf_rd), 32'd5);
        chk("alu rf_wdata", o_rf_wdata, 32'hDEAD_BEEF);
`ifdef WB_FORWARD_EN
        chk("alu fwd rs1", o_rs1_data, 32'hDEAD_BEEF);
        chk("alu fwd stall", 32'(o_stall), 32'h0);
`else
        chk("alu nofwd rs1", o_rs1_data, 32'hA1A1_0005);
        chk("alu nofwd stall", 32'(o_stall), 32'h1);
`endif
        tick(); idle();

        // Load hazard
        i_ld_issue = 1; i_ld_issue_rd = 7;
        tick();
        i_ld_issue = 0; i_rs2 = 7;
        @(negedge clk);
        chk("ld pending stall", 32'(o_stall), 32'h1);
        i_ld_valid = 1; i_ld_rd = 7; i_ld_data = 32'h1234_5678;
        tick();
        i_ld_valid = 0;
        @(negedge clk);
        chk("ld in fifo stall", 32'(o_stall), 32'h1);
        tick();
        @(negedge clk);
        chk("ld wb rf_wr", 32'(o_rf_wr), 32'h1);
        chk("ld wb rf_rd", 32'(o_rf_rd), 32'd7);
`ifdef WB_FORWARD_EN
        chk("ld wb stall", 32'(o_stall), 32'h0);
        chk("ld wb rs2", o_rs2_data, 32'h1234_5678);
`else
        chk("ld wb stall", 32'(o_stall), 32'h1);
`endif
        tick(); idle();
        @(negedge clk);
        chk("ld done stall", 32'(o_stall), 32'h0);
        tick();

        // Collision
        i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'h0000_0033;
        i_ld_valid = 1; i_ld_rd = 4; i_ld_data = 32'h0000_0044;
        tick(); idle();
        @(negedge clk);
        chk("coll first rd", 32'(o_rf_rd), 32'd3);
        chk("coll first data", o_rf_wdata, 32'h33);
        tick();
        @(negedge clk);
        chk("coll second wr", 32'(o_rf_wr), 32'h1);
        chk("coll second rd", 32'(o_rf_rd), 32'd4);
        chk("coll second data", o_rf_wdata, 32'h44);
        tick();
        @(negedge clk);
        chk("coll idle wr", 32'(o_rf_wr), 32'h0);

        // FIFO full
        i_alu_valid = 1; i_alu_rd = 1; i_alu_data = 32'h0000_0101;
        i_ld_valid = 1; i_ld_rd = 10; i_ld_data = 32'h0000_0A0A;
        tick();
        i_ld_rd = 11; i_ld_data = 32'h0000_0B0B;
        @(negedge clk);
        chk("fifo one ready", 32'(o_ld_ready), 32'h1);
        tick();
        i_ld_valid = 0;
        @(negedge clk);
        chk("fifo full ready", 32'(o_ld_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("fifo held ready", 32'(o_ld_ready), 32'h0);
        i_alu_valid = 0;
        tick();
        @(negedge clk);
        chk("drain1 rd", 32'(o_rf_rd), 32'd10);
        chk("drain1 data", o_rf_wdata, 32'h0A0A);
        chk("drain1 ready", 32'(o_ld_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("drain2 rd", 32'(o_rf_rd), 32'd11);
        chk("drain2 data", o_rf_wdata, 32'h0B0B);
        tick(); idle();

        // Load to x0
        i_ld_valid = 1; i_ld_rd = 0; i_ld_data = 32'h0000_0055;
        tick(); idle();
        tick();
        @(negedge clk);
        chk("x0 rf_wr", 32'(o_rf_wr), 32'h0);
        tick();

        // Set wins over clear on the same rd
        i_ld_issue = 1; i_ld_issue_rd = 9;
        tick(); idle();
        i_ld_valid = 1; i_ld_rd = 9; i_ld_data = 32'h0000_0999;
        tick(); idle();
        i_ld_issue = 1; i_ld_issue_rd = 9; i_rs1 = 9;
        tick();
        i_ld_issue = 0;
        @(negedge clk);
        chk("setwin rf_rd", 32'(o_rf_rd), 32'd9);
        chk("setwin stall", 32'(o_stall), 32'h1);
        i_ld_valid = 1; i_ld_rd = 9; i_ld_data = 32'h0000_0998;
        tick();
        i_ld_valid = 0;
        tick(); tick();
        @(negedge clk);
        chk("setwin cleared stall", 32'(o_stall), 32'h0);
        idle();

        // Reset mid-operation
        i_alu_valid = 1; i_alu_rd = 2; i_alu_data = 32'h0000_0202;
        i_ld_issue = 1; i_ld_issue_rd = 12;
        tick();
        i_ld_issue_rd = 13; i_ld_valid = 1; i_ld_rd = 12; i_ld_data = 32'h0000_0C0C;
        tick();
        i_ld_issue = 0; i_ld_rd = 13; i_ld_data = 32'h0000_0D0D;
        tick();
        i_ld_valid = 0; i_rs1 = 12; i_rs2 = 13;
        @(negedge clk);
        chk("prereset ready", 32'(o_ld_ready), 32'h0);
        chk("prereset stall", 32'(o_stall), 32'h1);
        rst = 1; i_ld_valid = 1; i_ld_issue = 1; i_ld_issue_rd = 14;
        tick();
        rst = 0;
        i_alu_valid = 0; i_ld_valid = 0; i_ld_issue = 0;
        @(negedge clk);
        chk("postreset rf_wr", 32'(o_rf_wr), 32'h0);
        chk("postreset ready", 32'(o_ld_ready), 32'h1);
        chk("postreset stall", 32'(o_stall), 32'h0);
        tick(); idle();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
